id_stage_pipe: RTL and testbench

Parametrised decode stage with an integrated ID/EX pipeline register. It reads operands from an internal register file with write-through bypass, selects the immediate and destination, and detects RAW hazards in one of two modes (forwarding or non-forwarding). It inserts bubbles on stall or flush and counts stall cycles. It sits between the IF/ID register and the EXE stage, and it takes decoded control fields from the external control unit.

---
 rtl/id_stage_pipe.sv | 164 ++++++++++++++++
 tb/tb_id_stage_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Decode stage with ID/EX pipeline register: register file with write-through
// bypass, immediate/destination select, RAW hazard detection and a stall counter.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      instr,
  input  logic             c_is_imm,
  input  logic             c_zext,
  input  logic             c_mem_r,
  input  logic             c_mem_w,
  input  logic             c_wb_en,
  input  logic             c_uses_src2,
  input  logic [3:0]       c_exe_cmd,
  input  logic [1:0]       c_br_type,
  input  logic             wb_en,
  input  logic [RW-1:0]    wb_dest,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [RW-1:0]    exe_dest,
  input  logic             mem_wb_en,
  input  logic [RW-1:0]    mem_dest,
  input  logic             flush,
  input  logic             freeze,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_mem_r,
  output logic             ex_mem_w,
  output logic             ex_wb_en,
  output logic [3:0]       ex_exe_cmd,
  output logic [1:0]       ex_br_type,
  output logic [RW-1:0]    ex_dest,
  output logic [RW-1:0]    ex_src1,
  output logic [RW-1:0]    ex_src2,
  output logic [XLEN-1:0]  ex_reg1,
  output logic [XLEN-1:0]  ex_reg2,
  output logic [XLEN-1:0]  ex_val2,
  output logic [CNT_W-1:0] stall_cnt
);

  // Handshake: in_valid qualifies instr and the control fields; the stage takes
  // them at a rising edge where stall is low, otherwise upstream must hold them.

  typedef struct packed {
    logic            valid;
    logic            mem_r;
    logic            mem_w;
    logic            wb_en;
    logic [3:0]      exe_cmd;
    logic [1:0]      br_type;
    logic [RW-1:0]   dest;
    logic [RW-1:0]   src1;
    logic [RW-1:0]   src2;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
    logic [XLEN-1:0] val2;
  } ex_t;

  logic [XLEN-1:0] rf [NREG];
  ex_t ex_q, ex_d, dec;

  logic [4:0]      f_src1, f_src2, f_rd;
  logic [RW-1:0]   src1, src2, rd_i, rt_i;
  logic [XLEN-1:0] rd1, rd2, imm_ext;
  logic            use2, m_exe, m_mem, hazard;
  logic            unused_bits;

  assign f_src1 = instr[25:21];
  assign f_src2 = instr[20:16];
  assign f_rd   = instr[15:11];
  assign src1   = f_src1[RW-1:0];
  assign rt_i   = f_src2[RW-1:0];
  assign rd_i   = f_rd[RW-1:0];
  assign src2   = rt_i;
  assign unused_bits = ^{instr[31:26], f_src1, f_src2, f_rd};

  assign imm_ext = c_zext ? {{(XLEN-16){1'b0}}, instr[15:0]}
                          : {{(XLEN-16){instr[15]}}, instr[15:0]};

  // Register 0 is hardwired to zero; a same-cycle write-back wins over storage.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (src1 != '0) rd1 = (wb_en && wb_dest == src1) ? wb_data : rf[src1];
    if (src2 != '0) rd2 = (wb_en && wb_dest == src2) ? wb_data : rf[src2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en && wb_dest != '0) begin
      rf[wb_dest] <= wb_data;
    end
  end

  assign use2 = ~c_is_imm | c_uses_src2;

  always_comb begin
    m_exe = exe_wb_en && ((src1 != '0 && exe_dest == src1) ||
                          (use2 && src2 != '0 && exe_dest == src2));
    m_mem = mem_wb_en && ((src1 != '0 && mem_dest == src1) ||
                          (use2 && src2 != '0 && mem_dest == src2));
    if (FWD_EN != 0) hazard = in_valid & m_exe & exe_mem_r_en;
    else             hazard = in_valid & (m_exe | m_mem);
  end

  assign stall = freeze | (hazard & ~flush);

  always_comb begin
    dec         = '0;
    dec.valid   = in_valid;
    dec.mem_r   = c_mem_r;
    dec.mem_w   = c_mem_w;
    dec.wb_en   = c_wb_en;
    dec.exe_cmd = c_exe_cmd;
    dec.br_type = c_br_type;
    dec.dest    = c_is_imm ? rt_i : rd_i;
    dec.src1    = src1;
    dec.src2    = use2 ? src2 : '0;
    dec.reg1    = rd1;
    dec.reg2    = rd2;
    dec.val2    = c_is_imm ? imm_ext : rd2;
  end

  // Flush beats freeze; an invalid slot loads a bubble like a hazard does.
  always_comb begin
    ex_d = '0;
    if (flush)                    ex_d = '0;
    else if (freeze)              ex_d = ex_q;
    else if (hazard || !in_valid) ex_d = '0;
    else                          ex_d = dec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q      <= '0;
      stall_cnt <= '0;
    end else begin
      ex_q <= ex_d;
      if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_mem_r   = ex_q.mem_r;
  assign ex_mem_w   = ex_q.mem_w;
  assign ex_wb_en   = ex_q.wb_en;
  assign ex_exe_cmd = ex_q.exe_cmd;
  assign ex_br_type = ex_q.br_type;
  assign ex_dest    = ex_q.dest;
  assign ex_src1    = ex_q.src1;
  assign ex_src2    = ex_q.src2;
  assign ex_reg1    = ex_q.reg1;
  assign ex_reg2    = ex_q.reg2;
  assign ex_val2    = ex_q.val2;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a forwarding instance and a non-forwarding
// instance share stimulus; both use an 8-bit stall counter to reach saturation.
module tb_id_stage_pipe;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [31:0] instr;
  logic c_is_imm, c_zext, c_mem_r, c_mem_w, c_wb_en, c_uses_src2;
  logic [3:0] c_exe_cmd;
  logic [1:0] c_br_type;
  logic wb_en;
  logic [RW-1:0] wb_dest;
  logic [XLEN-1:0] wb_data;
  logic exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic [RW-1:0] exe_dest, mem_dest;
  logic flush, freeze;

  logic a_stall, a_valid, a_mem_r, a_mem_w, a_wb_en;
  logic [3:0] a_cmd;
  logic [1:0] a_br;
  logic [RW-1:0] a_dest, a_src1, a_src2;
  logic [XLEN-1:0] a_reg1, a_reg2, a_val2;
  logic [CW-1:0] a_cnt;

  logic b_stall, b_valid, b_mem_r, b_mem_w, b_wb_en;
  logic [3:0] b_cmd;
  logic [1:0] b_br;
  logic [RW-1:0] b_dest, b_src1, b_src2;
  logic [XLEN-1:0] b_reg1, b_reg2, b_val2;
  logic [CW-1:0] b_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .NREG(32), .FWD_EN(1), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .c_is_imm(c_is_imm), .c_zext(c_zext), .c_mem_r(c_mem_r), .c_mem_w(c_mem_w),
    .c_wb_en(c_wb_en), .c_uses_src2(c_uses_src2), .c_exe_cmd(c_exe_cmd),
    .c_br_type(c_br_type), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .flush(flush), .freeze(freeze),
    .stall(a_stall), .ex_valid(a_valid), .ex_mem_r(a_mem_r), .ex_mem_w(a_mem_w),
    .ex_wb_en(a_wb_en), .ex_exe_cmd(a_cmd), .ex_br_type(a_br), .ex_dest(a_dest),
    .ex_src1(a_src1), .ex_src2(a_src2), .ex_reg1(a_reg1), .ex_reg2(a_reg2),
    .ex_val2(a_val2), .stall_cnt(a_cnt)
  );

  id_stage_pipe #(.XLEN(XLEN), .NREG(32), .FWD_EN(0), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .c_is_imm(c_is_imm), .c_zext(c_zext), .c_mem_r(c_mem_r), .c_mem_w(c_mem_w),
    .c_wb_en(c_wb_en), .c_uses_src2(c_uses_src2), .c_exe_cmd(c_exe_cmd),
    .c_br_type(c_br_type), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .flush(flush), .freeze(freeze),
    .stall(b_stall), .ex_valid(b_valid), .ex_mem_r(b_mem_r), .ex_mem_w(b_mem_w),
    .ex_wb_en(b_wb_en), .ex_exe_cmd(b_cmd), .ex_br_type(b_br), .ex_dest(b_dest),
    .ex_src1(b_src1), .ex_src2(b_src2), .ex_reg1(b_reg1), .ex_reg2(b_reg2),
    .ex_val2(b_val2), .stall_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] s1, input logic [4:0] s2,
                                     input logic [15:0] imm);
    return {6'b0, s1, s2, imm};
  endfunction

  function automatic logic [31:0] mkr(input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [4:0] rd);
    return {6'b0, s1, s2, rd, 11'b0};
  endfunction

  task automatic idle();
    in_valid = 0; instr = '0;
    c_is_imm = 0; c_zext = 0; c_mem_r = 0; c_mem_w = 0; c_wb_en = 0; c_uses_src2 = 0;
    c_exe_cmd = '0; c_br_type = '0;
    wb_en = 0; wb_dest = '0; wb_data = '0;
    exe_wb_en = 0; exe_mem_r_en = 0; exe_dest = '0;
    mem_wb_en = 0; mem_dest = '0;
    flush = 0; freeze = 0;
  endtask

  // Inputs change 1 time unit after a rising edge; combinational checks follow 1 later.
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #2;
    chk("reset_valid", a_valid, 1'b0);
    chk("reset_cnt", a_cnt, '0);
    edge_wait();
    rst = 1'b1;
    edge_wait();

    // Bypass: write r3 and read it in the same cycle
    idle();
    in_valid = 1; instr = mkr(5'd3, 5'd0, 5'd9);
    c_exe_cmd = 4'h5; c_br_type = 2'd2; c_wb_en = 1;
    wb_en = 1; wb_dest = 5'd3; wb_data = 32'hDEADBEEF;
    #1 chk("bypass_stall", a_stall, 1'b0);
    edge_wait();
    chk("bypass_reg1", a_reg1, 32'hDEADBEEF);
    chk("bypass_valid", a_valid, 1'b1);
    chk("bypass_dest", a_dest, 5'd9);
    chk("bypass_cmd", a_cmd, 4'h5);
    chk("bypass_br", a_br, 2'd2);
    chk("bypass_val2", a_val2, 32'h0);

    // Stored r3 on src1, bypassed r6 on src2
    idle();
    in_valid = 1; instr = mkr(5'd3, 5'd6, 5'd1);
    wb_en = 1; wb_dest = 5'd6; wb_data = 32'h12345678;
    edge_wait();
    chk("rf_reg1", a_reg1, 32'hDEADBEEF);
    chk("rf_reg2", a_reg2, 32'h12345678);
    chk("rf_val2", a_val2, 32'h12345678);
    chk("rf_dest", a_dest, 5'd1);

    // Writes to r0 are ignored
    idle();
    in_valid = 1; instr = mkr(5'd0, 5'd0, 5'd2);
    wb_en = 1; wb_dest = 5'd0; wb_data = 32'hFFFFFFFF;
    edge_wait();
    chk("r0_reg1", a_reg1, 32'h0);
    chk("r0_reg2", a_reg2, 32'h0);

    // Sign-extended immediate
    idle();
    in_valid = 1; c_is_imm = 1; instr = mk(5'd6, 5'd10, 16'h8001);
    edge_wait();
    chk("imm_sext", a_val2, 32'hFFFF8001);
    chk("imm_dest", a_dest, 5'd10);
    chk("imm_src2_zero", a_src2, 5'd0);
    chk("imm_reg1", a_reg1, 32'h12345678);

    // Zero-extended immediate with src2 in use
    idle();
    in_valid = 1; c_is_imm = 1; c_zext = 1; c_uses_src2 = 1; instr = mk(5'd6, 5'd6, 16'h8001);
    edge_wait();
    chk("imm_zext", a_val2, 32'h00008001);
    chk("imm_src2_used", a_src2, 5'd6);
    chk("imm_reg2", a_reg2, 32'h12345678);

    // Load-use on src2
    idle();
    in_valid = 1; instr = mkr(5'd1, 5'd4, 5'd2);
    exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5'd4;
    #1;
    chk("lu_stall_a", a_stall, 1'b1);
    chk("lu_stall_b", b_stall, 1'b1);
    edge_wait();
    chk("lu_bubble_valid", a_valid, 1'b0);
    chk("lu_bubble_src2", a_src2, 5'd0);
    chk("lu_cnt_a", a_cnt, 8'd1);
    chk("lu_cnt_b", b_cnt, 8'd1);

    // Plain ALU producer: forwarding resolves it, non-forwarding still stalls
    exe_mem_r_en = 0;
    #1;
    chk("alu_stall_a", a_stall, 1'b0);
    chk("alu_stall_b", b_stall, 1'b1);
    edge_wait();
    chk("alu_valid_a", a_valid, 1'b1);
    chk("alu_src2_a", a_src2, 5'd4);
    chk("alu_cnt_a", a_cnt, 8'd1);
    chk("alu_cnt_b", b_cnt, 8'd2);

    // Unused src2 field does not create a hazard
    idle();
    in_valid = 1; c_is_imm = 1; instr = mk(5'd1, 5'd4, 16'h0003);
    exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5'd4;
    #1;
    chk("nosrc2_stall_a", a_stall, 1'b0);
    chk("nosrc2_stall_b", b_stall, 1'b0);
    edge_wait();

    // MEM-stage producer for the non-forwarding mode
    idle();
    in_valid = 1; c_is_imm = 1; instr = mk(5'd7, 5'd0, 16'h0001);
    mem_wb_en = 1; mem_dest = 5'd7;
    #1;
    chk("mem_stall_b", b_stall, 1'b1);
    chk("mem_stall_a", a_stall, 1'b0);
    edge_wait();
    chk("mem_cnt_b", b_cnt, 8'd3);

    idle();
    in_valid = 1; c_is_imm = 1; instr = mk(5'd0, 5'd0, 16'h0001);
    mem_wb_en = 1; mem_dest = 5'd0;
    #1 chk("r0_nohaz_b", b_stall, 1'b0);
    edge_wait();

    idle();
    in_valid = 0; c_is_imm = 1; instr = mk(5'd7, 5'd0, 16'h0001);
    mem_wb_en = 1; mem_dest = 5'd7;
    #1 chk("invalid_nohaz_b", b_stall, 1'b0);
    edge_wait();
    chk("invalid_bubble_a", a_valid, 1'b0);
    chk("invalid_cnt_b", b_cnt, 8'd3);

    // Load a valid instruction, then flush together with a hazard
    idle();
    in_valid = 1; instr = mkr(5'd3, 5'd6, 5'd2); c_exe_cmd = 4'h7;
    edge_wait();
    chk("pre_flush_valid", a_valid, 1'b1);
    idle();
    in_valid = 1; instr = mkr(5'd1, 5'd4, 5'd2); c_exe_cmd = 4'h3;
    exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5'd4; flush = 1;
    #1 chk("flush_haz_stall", a_stall, 1'b0);
    edge_wait();
    chk("flush_haz_valid", a_valid, 1'b0);
    chk("flush_haz_cmd", a_cmd, 4'h0);
    chk("flush_haz_cnt", a_cnt, 8'd1);

    // Freeze holds a loaded instruction; also write r5 for later
    idle();
    in_valid = 1; instr = mkr(5'd3, 5'd6, 5'd2); c_exe_cmd = 4'h7;
    wb_en = 1; wb_dest = 5'd5; wb_data = 32'hA5A5A5A5;
    edge_wait();
    idle();
    in_valid = 1; instr = mkr(5'd0, 5'd0, 5'd1); c_exe_cmd = 4'h1; freeze = 1;
    #1 chk("freeze_stall", a_stall, 1'b1);
    edge_wait();
    chk("freeze_valid", a_valid, 1'b1);
    chk("freeze_cmd", a_cmd, 4'h7);
    chk("freeze_reg1", a_reg1, 32'hDEADBEEF);
    chk("freeze_cnt", a_cnt, 8'd2);

    // Flush beats freeze, stall stays high
    flush = 1;
    #1 chk("flush_freeze_stall", a_stall, 1'b1);
    edge_wait();
    chk("flush_freeze_valid", a_valid, 1'b0);
    chk("flush_freeze_cnt", a_cnt, 8'd3);

    // Counter saturation
    idle();
    freeze = 1;
    repeat (300) @(posedge clk);
    #1;
    chk("sat_cnt_a", a_cnt, 8'hFF);
    chk("sat_cnt_b", b_cnt, 8'hFF);

    // Read r5, then reset mid-stall between edges
    idle();
    in_valid = 1; instr = mkr(5'd5, 5'd5, 5'd8); c_exe_cmd = 4'h9;
    edge_wait();
    chk("r5_before_reset", a_reg1, 32'hA5A5A5A5);
    chk("sat_hold_cnt", a_cnt, 8'hFF);
    idle();
    freeze = 1;
    #2 rst = 1'b0;
    #1;
    chk("async_valid", a_valid, 1'b0);
    chk("async_cmd", a_cmd, 4'h0);
    chk("async_reg1", a_reg1, 32'h0);
    chk("async_cnt", a_cnt, 8'h0);
    chk("async_stall", a_stall, 1'b1);
    edge_wait();
    rst = 1'b1;
    idle();
    in_valid = 1; instr = mkr(5'd5, 5'd0, 5'd8);
    edge_wait();
    chk("r5_after_reset", a_reg1, 32'h0);
    chk("post_reset_valid", a_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
